micro_sequencer: RTL and testbench
==================================

// Module: micro_sequencer
// PURPOSE
// Parametrised microcode sequencer for the SAP control unit: owns the T-state step counter, forms the
// microcode ROM address {opcode, step}, and gates the returned control word onto CTRL.
// Adds early end-of-instruction (END bit), single-step enable, a halt/resume state and a retired-instruction counter.
// Sits between the instruction register and the microcode ROM; CTRL drives every datapath load/enable.
// PARAMETERS
// OPCODE_W    4      opcode width (IR upper field)
// STEP_W      3      step counter width
// CTRL_W      18     control word width
// MAX_STEPS   6      last step index + 1; step wraps to 0 after MAX_STEPS-1 (MAX_STEPS <= 2**STEP_W)
// FETCH_STEPS 2      shared fetch steps; opcode field forced to 0 in UADDR while step < FETCH_STEPS
// HALT_OP     4'hF   opcode that enters HALT at the first execute step
// CNT_W       16     retired-instruction counter width
// PORTS
// CLK       in   1                    rising-edge clock
// CLR_n     in   1                    synchronous active-low reset
// EN        in   1                    step enable; 0 freezes step, state and counter
// RESUME    in   1                    1-cycle pulse: leave HALT
// IR_OP     in   OPCODE_W             opcode from instruction register
// UWORD     in   CTRL_W+1             microcode ROM data; [CTRL_W] = END, [CTRL_W-1:0] = control word
// UADDR     out  OPCODE_W+STEP_W      microcode ROM address
// CTRL      out  CTRL_W               control word to datapath
// STEP      out  STEP_W               current step
// HLT       out  1                    1 while in HALT
// INSTR_CNT out  CNT_W                instructions retired
// BEHAVIOUR
// - Sync reset (CLR_n=0 at edge): state=IDLE, step=0, INSTR_CNT=0; reset beats EN, RESUME, mid-instruction work.
// - States: IDLE -> RUN (next edge, unconditional); RUN -> HALT; HALT -> RUN on RESUME; any -> IDLE on reset.
// - IDLE: CTRL=0, HLT=0, UADDR={0,0}, step held at 0. One dead cycle after reset, no EN needed.
// - UADDR combinational: {0, step} if step < FETCH_STEPS else {IR_OP, step}.
// - CTRL combinational = UWORD[CTRL_W-1:0] in RUN, else 0. Zero added latency (ROM assumed async).
// - RUN, EN=1: end_instr = UWORD[CTRL_W] | (step == MAX_STEPS-1).
//     end_instr: step<=0, INSTR_CNT<=INSTR_CNT+1 (wraps mod 2**CNT_W); else step<=step+1.
// - END ignored while step < FETCH_STEPS (fetch cannot be cut short).
// - HALT entry: RUN, EN=1, step==FETCH_STEPS, IR_OP==HALT_OP -> state HALT, step<=0,
//   INSTR_CNT+1 (HLT counts as retired). The HLT step's CTRL word is output for that cycle.
// - HALT: CTRL=0, HLT=1, step held 0, EN ignored. RESUME=1 -> RUN at step 0 (next fetch).
// - RESUME outside HALT: ignored.
// - RUN, EN=0: all state frozen; CTRL still follows UWORD (control asserted, no step advance).
//   Datapath qualifies loads with the same EN.
// - Simultaneous end_instr and HALT entry: HALT wins; counter still +1 once.
// - Outputs other than CTRL/UADDR registered; STEP, HLT, INSTR_CNT change only on CLK edge.
// TESTING
// 1 Reset: CLR_n=0 two edges -> STEP=0, HLT=0, INSTR_CNT=0, CTRL=0; release -> 1 IDLE cycle, then RUN, UADDR=7'b0000000.
// 2 Fetch+early END: IR_OP=4'h1, ROM END set at step 3 -> STEP 0,1,2,3,0; UADDR 000,001,0001010,0001011; INSTR_CNT=1.
// 3 Full length: no END bits, IR_OP=4'h2 -> steps 0..5 then 0; INSTR_CNT increments on step-5 edge only.
// 4 Halt/resume: IR_OP=4'hF at step 2 -> HLT=1, CTRL=0 for 10 cycles; EN toggling ignored; RESUME pulse -> RUN, STEP=0.
// 5 Single-step: EN=0 for 5 cycles at step 3 -> STEP stays 3, CTRL=UWORD[17:0]; EN=1 -> STEP=4.
// 6 Mid-op reset: CLR_n=0 at step 4 with END pending -> STEP=0, INSTR_CNT=0, IDLE; INSTR_CNT at 16'hFFFF + retire -> 0.

Source files
------------

// File: rtl/micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : micro_sequencer
// Purpose  : Microcode sequencer for the SAP control unit. Owns the T-state
//            step counter, forms the microcode ROM address {opcode, step} and
//            gates the returned control word onto o_ctrl. Supports early
//            end-of-instruction (END bit), single-step enable, a halt/resume
//            state and a retired-instruction counter.
// Ports    : i_clk        rising-edge clock
//            i_clr_n      synchronous active-low reset
//            i_en         step enable; 0 freezes step, state and counter
//            i_resume     one-cycle pulse that leaves HALT
//            i_ir_op      opcode from the instruction register
//            i_uword      microcode ROM data: [CTRL_W] = END, rest = control
//            o_uaddr      microcode ROM address (combinational)
//            o_ctrl       control word to datapath (combinational)
//            o_step       current step (registered)
//            o_hlt        1 while halted (registered)
//            o_instr_cnt  instructions retired (registered, wraps)
// Revision : 1.0 - initial release
// ============================================================================
module micro_sequencer #(
  parameter int                    OPCODE_W    = 4,
  parameter int                    STEP_W      = 3,
  parameter int                    CTRL_W      = 18,
  parameter int                    MAX_STEPS   = 6,
  parameter int                    FETCH_STEPS = 2,
  parameter logic [OPCODE_W-1:0]   HALT_OP     = {OPCODE_W{1'b1}},
  parameter int                    CNT_W       = 16
) (
  input  logic                       i_clk,
  input  logic                       i_clr_n,
  input  logic                       i_en,
  input  logic                       i_resume,
  input  logic [OPCODE_W-1:0]        i_ir_op,
  input  logic [CTRL_W:0]            i_uword,
  output logic [OPCODE_W+STEP_W-1:0] o_uaddr,
  output logic [CTRL_W-1:0]          o_ctrl,
  output logic [STEP_W-1:0]          o_step,
  output logic                       o_hlt,
  output logic [CNT_W-1:0]           o_instr_cnt
);

  localparam logic [STEP_W-1:0] C_LAST_STEP  = STEP_W'(MAX_STEPS - 1);
  localparam logic [STEP_W-1:0] C_FETCH_STEP = STEP_W'(FETCH_STEPS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t             r_state;
  logic [STEP_W-1:0]  r_step;
  logic [CNT_W-1:0]   r_instr_cnt;
  logic               r_hlt;

  logic               w_in_fetch;
  logic               w_end_instr;
  logic               w_halt_entry;

  // Fetch steps are shared by every opcode, so the opcode field is masked
  // until the first execute step.
  assign w_in_fetch = (r_step < C_FETCH_STEP);

  // END from the ROM cannot shorten the fetch; the last step always ends.
  assign w_end_instr  = (i_uword[CTRL_W] & ~w_in_fetch) | (r_step == C_LAST_STEP);
  assign w_halt_entry = (r_step == C_FETCH_STEP) && (i_ir_op == HALT_OP);

  assign o_uaddr = w_in_fetch ? {{OPCODE_W{1'b0}}, r_step} : {i_ir_op, r_step};

  // The ROM is asynchronous, so the control word passes straight through
  // while running (including while EN=0; the datapath qualifies with EN).
  assign o_ctrl = (r_state == S_RUN) ? i_uword[CTRL_W-1:0] : '0;

  assign o_step      = r_step;
  assign o_hlt       = r_hlt;
  assign o_instr_cnt = r_instr_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_state     <= S_IDLE;
      r_step      <= '0;
      r_instr_cnt <= '0;
      r_hlt       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_RUN;
          r_step  <= '0;
        end
        S_RUN: begin
          if (i_en) begin
            if (w_halt_entry) begin
              // Halt takes priority over any END on the same step; the HLT
              // instruction itself counts as retired exactly once.
              r_state     <= S_HALT;
              r_hlt       <= 1'b1;
              r_step      <= '0;
              r_instr_cnt <= r_instr_cnt + CNT_W'(1);
            end else if (w_end_instr) begin
              r_step      <= '0;
              r_instr_cnt <= r_instr_cnt + CNT_W'(1);
            end else begin
              r_step <= r_step + STEP_W'(1);
            end
          end
        end
        S_HALT: begin
          r_step <= '0;
          if (i_resume) begin
            r_state <= S_RUN;
            r_hlt   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_step  <= '0;
          r_hlt   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_micro_sequencer
// Purpose  : Self-checking bench for micro_sequencer. A behavioural model of
//            the instruction sequencing rules runs alongside the design; a
//            second instance with a 3-bit counter exercises counter wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_micro_sequencer;

  localparam int         FETCH = 2;
  localparam int         MAXS  = 6;
  localparam logic [3:0] HOP   = 4'hF;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        en = 1'b0;
  logic        resume = 1'b0;
  logic [3:0]  ir_op = 4'h0;
  logic [18:0] uword, uword_s;
  logic [6:0]  uaddr, uaddr_s;
  logic [17:0] ctrl, ctrl_s;
  logic [2:0]  step, step_s;
  logic        hlt, hlt_s;
  logic [15:0] cnt;
  logic [2:0]  cnt_s;

  logic [18:0] rom [128];

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: 0 = idle, 1 = run, 2 = halt
  int m_state = 0;
  int m_step  = 0;
  int m_cnt   = 0;
  int m_cnt_s = 0;

  always #5 clk = ~clk;

  assign uword   = rom[uaddr];
  assign uword_s = rom[uaddr_s];

  micro_sequencer dut (
    .i_clk(clk), .i_clr_n(clr_n), .i_en(en), .i_resume(resume), .i_ir_op(ir_op),
    .i_uword(uword), .o_uaddr(uaddr), .o_ctrl(ctrl), .o_step(step), .o_hlt(hlt),
    .o_instr_cnt(cnt)
  );

  micro_sequencer #(.CNT_W(3)) dut_s (
    .i_clk(clk), .i_clr_n(clr_n), .i_en(en), .i_resume(resume), .i_ir_op(ir_op),
    .i_uword(uword_s), .o_uaddr(uaddr_s), .o_ctrl(ctrl_s), .o_step(step_s), .o_hlt(hlt_s),
    .o_instr_cnt(cnt_s)
  );

  function automatic logic [6:0] exp_uaddr(input logic [3:0] op);
    if (m_step < FETCH) return {4'h0, 3'(m_step)};
    return {op, 3'(m_step)};
  endfunction

  function automatic logic [17:0] exp_ctrl(input logic [3:0] op);
    logic [18:0] w;
    w = rom[exp_uaddr(op)];
    if (m_state != 1) return '0;
    return w[17:0];
  endfunction

  task automatic model_edge(input bit c, input bit e, input bit r, input logic [3:0] op);
    logic [18:0] w;
    bit retire;
    w = rom[exp_uaddr(op)];
    retire = 0;
    if (!c) begin
      m_state = 0; m_step = 0; m_cnt = 0; m_cnt_s = 0;
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1 && e) begin
      if (m_step == FETCH && op == HOP) begin
        m_state = 2; m_step = 0; retire = 1;
      end else if ((w[18] && m_step >= FETCH) || m_step == MAXS - 1) begin
        m_step = 0; retire = 1;
      end else begin
        m_step = m_step + 1;
      end
    end else if (m_state == 2 && r) begin
      m_state = 1;
    end
    if (retire) begin
      m_cnt   = (m_cnt + 1) % 65536;
      m_cnt_s = (m_cnt_s + 1) % 8;
    end
  endtask

  // One clock: drive inputs on the falling edge, advance the model on the
  // rising edge, then leave outputs settled for the caller to inspect.
  task automatic tick(input bit c, input bit e, input bit r, input logic [3:0] op);
    @(negedge clk);
    clr_n = c; en = e; resume = r; ir_op = op;
    @(posedge clk);
    model_edge(c, e, r, op);
    #1;
  endtask

  task automatic reset_run(input logic [3:0] op);
    tick(0, 1, 0, op);
    tick(1, 1, 0, op);
  endtask

  // Random control words, END clear everywhere except the fetch words
  // (which must be ignored there).
  task automatic program_rom();
    for (int i = 0; i < 128; i++) rom[i] = {1'b0, 18'($urandom) | 18'h1};
    rom[0][18] = 1'b1;
    rom[1][18] = 1'b1;
  endtask

  task automatic test_reset();
    program_rom();
    tick(0, 1, 1, 4'h5);
    tick(0, 1, 0, 4'h5);
    n_checks++; if (step !== 3'd0) begin n_errors++; $display("FAIL reset_step: got %0d want 0", step); end
    n_checks++; if (hlt !== 1'b0) begin n_errors++; $display("FAIL reset_hlt: got %b want 0", hlt); end
    n_checks++; if (cnt !== 16'd0) begin n_errors++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
    n_checks++; if (ctrl !== 18'd0) begin n_errors++; $display("FAIL reset_ctrl_idle: got %h want 0", ctrl); end
    n_checks++; if (uaddr !== 7'd0) begin n_errors++; $display("FAIL reset_uaddr: got %b want 0", uaddr); end
    tick(1, 0, 0, 4'h5);
    n_checks++; if (ctrl !== rom[0][17:0]) begin n_errors++; $display("FAIL reset_run_ctrl: got %h want %h", ctrl, rom[0][17:0]); end
    n_checks++; if (uaddr !== 7'b0000000) begin n_errors++; $display("FAIL reset_run_uaddr: got %b want 0", uaddr); end
  endtask

  task automatic test_early_end();
    int          es [5] = '{0, 1, 2, 3, 0};
    logic [6:0]  ea [4] = '{7'b0000000, 7'b0000001, 7'b0001010, 7'b0001011};
    program_rom();
    rom[{4'h1, 3'd3}][18] = 1'b1;
    reset_run(4'h1);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (step !== 3'(es[i])) begin n_errors++; $display("FAIL end_step[%0d]: got %0d want %0d", i, step, es[i]); end
      if (i < 4) begin
        n_checks++; if (uaddr !== ea[i]) begin n_errors++; $display("FAIL end_uaddr[%0d]: got %b want %b", i, uaddr, ea[i]); end
        n_checks++; if (ctrl !== exp_ctrl(4'h1)) begin n_errors++; $display("FAIL end_ctrl[%0d]: got %h want %h", i, ctrl, exp_ctrl(4'h1)); end
        tick(1, 1, 0, 4'h1);
      end
    end
    n_checks++; if (cnt !== 16'd1) begin n_errors++; $display("FAIL end_cnt: got %0d want 1", cnt); end
  endtask

  task automatic test_full_length();
    program_rom();
    reset_run(4'h2);
    for (int i = 0; i < 7; i++) begin
      n_checks++; if (step !== 3'(i % 6)) begin n_errors++; $display("FAIL full_step[%0d]: got %0d want %0d", i, step, i % 6); end
      n_checks++; if (cnt !== 16'((i == 6) ? 1 : 0)) begin n_errors++; $display("FAIL full_cnt[%0d]: got %0d want %0d", i, cnt, (i == 6) ? 1 : 0); end
      if (i < 6) tick(1, 1, 0, 4'h2);
    end
  endtask

  task automatic test_halt_resume();
    program_rom();
    reset_run(HOP);
    tick(1, 1, 0, HOP);
    tick(1, 1, 0, HOP);
    n_checks++; if (uaddr !== 7'h7A) begin n_errors++; $display("FAIL halt_uaddr: got %h want 7a", uaddr); end
    n_checks++; if (ctrl !== rom[7'h7A][17:0]) begin n_errors++; $display("FAIL halt_step_ctrl: got %h want %h", ctrl, rom[7'h7A][17:0]); end
    tick(1, 1, 0, HOP);
    for (int k = 0; k < 10; k++) begin
      n_checks++; if (hlt !== 1'b1) begin n_errors++; $display("FAIL halt_hlt[%0d]: got %b want 1", k, hlt); end
      n_checks++; if (ctrl !== 18'd0) begin n_errors++; $display("FAIL halt_ctrl[%0d]: got %h want 0", k, ctrl); end
      n_checks++; if (step !== 3'd0) begin n_errors++; $display("FAIL halt_step[%0d]: got %0d want 0", k, step); end
      n_checks++; if (cnt !== 16'd1) begin n_errors++; $display("FAIL halt_cnt[%0d]: got %0d want 1", k, cnt); end
      tick(1, 1'($urandom_range(0, 1)), 0, HOP);
    end
    tick(1, 1, 1, HOP);
    n_checks++; if (hlt !== 1'b0) begin n_errors++; $display("FAIL resume_hlt: got %b want 0", hlt); end
    n_checks++; if (step !== 3'd0) begin n_errors++; $display("FAIL resume_step: got %0d want 0", step); end
    n_checks++; if (ctrl !== rom[0][17:0]) begin n_errors++; $display("FAIL resume_ctrl: got %h want %h", ctrl, rom[0][17:0]); end
    // RESUME while running must have no effect.
    tick(1, 1, 1, HOP);
    n_checks++; if (step !== 3'd1 || hlt !== 1'b0) begin n_errors++; $display("FAIL resume_in_run: got step %0d hlt %b want 1 0", step, hlt); end
  endtask

  task automatic test_single_step();
    program_rom();
    reset_run(4'h3);
    repeat (3) tick(1, 1, 0, 4'h3);
    for (int k = 0; k < 5; k++) begin
      tick(1, 0, 0, 4'h3);
      n_checks++; if (step !== 3'd3) begin n_errors++; $display("FAIL sstep_step[%0d]: got %0d want 3", k, step); end
      n_checks++; if (ctrl !== rom[7'h1B][17:0]) begin n_errors++; $display("FAIL sstep_ctrl[%0d]: got %h want %h", k, ctrl, rom[7'h1B][17:0]); end
    end
    tick(1, 1, 0, 4'h3);
    n_checks++; if (step !== 3'd4) begin n_errors++; $display("FAIL sstep_advance: got %0d want 4", step); end
  endtask

  task automatic test_mid_reset();
    program_rom();
    rom[{4'h4, 3'd4}][18] = 1'b1;
    reset_run(4'h4);
    repeat (5) tick(1, 1, 0, 4'h4);
    n_checks++; if (cnt !== 16'd1 || step !== 3'd0) begin n_errors++; $display("FAIL midrst_pre: got cnt %0d step %0d want 1 0", cnt, step); end
    repeat (4) tick(1, 1, 0, 4'h4);
    n_checks++; if (step !== 3'd4) begin n_errors++; $display("FAIL midrst_step4: got %0d want 4", step); end
    tick(0, 1, 1, 4'h4);
    n_checks++; if (step !== 3'd0 || cnt !== 16'd0) begin n_errors++; $display("FAIL midrst_state: got step %0d cnt %0d want 0 0", step, cnt); end
    n_checks++; if (ctrl !== 18'd0 || hlt !== 1'b0) begin n_errors++; $display("FAIL midrst_idle: got ctrl %h hlt %b want 0 0", ctrl, hlt); end
  endtask

  task automatic test_cnt_wrap();
    program_rom();
    reset_run(4'h2);
    for (int k = 1; k <= 9; k++) begin
      repeat (6) tick(1, 1, 0, 4'h2);
      n_checks++; if (cnt_s !== 3'(k % 8)) begin n_errors++; $display("FAIL wrap_cnt_s[%0d]: got %0d want %0d", k, cnt_s, k % 8); end
      n_checks++; if (cnt !== 16'(k)) begin n_errors++; $display("FAIL wrap_cnt[%0d]: got %0d want %0d", k, cnt, k); end
    end
  endtask

  task automatic test_random();
    bit c, e, r;
    logic [3:0] op;
    for (int i = 0; i < 128; i++) rom[i] = {1'($urandom_range(0, 3) == 0), 18'($urandom)};
    reset_run(4'h0);
    for (int i = 0; i < 400; i++) begin
      c  = ($urandom_range(0, 49) != 0);
      e  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 7) == 0);
      op = ($urandom_range(0, 3) == 0) ? HOP : 4'($urandom);
      tick(c, e, r, op);
      n_checks++;
      if (step !== 3'(m_step) || hlt !== (m_state == 2) || cnt !== 16'(m_cnt) ||
          cnt_s !== 3'(m_cnt_s) || uaddr !== exp_uaddr(op) || ctrl !== exp_ctrl(op)) begin
        n_errors++;
        $display("FAIL random[%0d]: got step %0d hlt %b cnt %0d cnt_s %0d uaddr %h ctrl %h want %0d %b %0d %0d %h %h",
                 i, step, hlt, cnt, cnt_s, uaddr, ctrl, m_step, (m_state == 2), m_cnt, m_cnt_s,
                 exp_uaddr(op), exp_ctrl(op));
      end
    end
  endtask

  initial begin
    test_reset();
    test_early_end();
    test_full_length();
    test_halt_resume();
    test_single_step();
    test_mid_reset();
    test_cnt_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
